hyperload_feeder: RTL

- Supplies the byte stream consumed by the hyperload fast-load routine patched into the Galaksija ROM.
- Accepts bytes from an upstream source (SD/SPI loader or OSD file reader) over a valid/ready handshake and buffers them in a small FIFO.
- Presents the bytes to the Z80 at a memory-mapped data address, with a status byte at a second address.
- Drives the override enable of the ROM patch for the duration of a load session.

---
 rtl/hyperload_feeder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hyperload_feeder.sv
// Byte feeder for the hyperload fast-load routine: upstream bytes are buffered in a FIFO
// and handed to the Z80 through a memory-mapped data port, with a status port next to it.
//
// state  | meaning
// IDLE   | no session; ROM patch off, upstream stalled, FIFO empty
// ARMED  | session started, waiting for the first byte of the file
// STREAM | bytes flowing; watchdog counts down between CPU pops
// DRAIN  | final byte received; CPU empties the FIFO, upstream stalled
module hyperload_feeder #(
    parameter int          DEPTH     = 16,
    parameter logic [15:0] DATA_ADDR = 16'h2040,
    parameter logic [15:0] STAT_ADDR = 16'h2041,
    parameter logic [23:0] TIMEOUT   = 24'd3_500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    input  logic [15:0] a,
    input  logic        cpu_rd,
    output logic [7:0]  q,
    output logic        sel,
    output logic        override,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t         state;
    logic [8:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           eof_seen;
    logic           timeout_flag;
    logic [23:0]    wd_cnt;

    logic           active;
    logic           empty;
    logic           full;
    logic           hit_data;
    logic           hit_stat;
    logic           push;
    logic           pop;
    logic           last_push;
    logic [8:0]     head;
    logic           timeout_hit;
    logic           abort_hit;
    logic           start_hit;
    logic           flush;

    assign active    = (state != IDLE);
    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign hit_data  = (a == DATA_ADDR);
    assign hit_stat  = (a == STAT_ADDR);
    assign head      = mem[rd_ptr];

    assign s_ready   = ((state == ARMED) || (state == STREAM)) && !full;
    assign busy      = active;

    assign push      = s_valid && s_ready;
    assign last_push = push && s_last;
    assign pop       = cpu_rd && hit_data && !empty && active;

    // The final byte takes precedence over a watchdog expiry in the same cycle.
    assign timeout_hit = (state == STREAM) && !last_push && !pop && (wd_cnt == '0);
    assign abort_hit   = abort && active;
    assign start_hit   = start && (state == IDLE);
    assign flush       = start_hit || abort_hit || timeout_hit;

    // Storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_last, s_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q   <= 8'h00;
            sel <= 1'b0;
        end else begin
            sel <= (hit_data || hit_stat) && active;
            if (hit_data) begin
                q <= empty ? 8'hFF : head[7:0];
            end else if (hit_stat) begin
                q <= {4'b0000, timeout_flag, eof_seen, override, !empty};
            end else begin
                q <= 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            override     <= 1'b0;
            eof_seen     <= 1'b0;
            timeout_flag <= 1'b0;
            wd_cnt       <= '0;
        end else if (abort_hit) begin
            state    <= IDLE;
            override <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    override <= 1'b0;
                    if (start_hit) begin
                        state        <= ARMED;
                        override     <= 1'b1;
                        eof_seen     <= 1'b0;
                        timeout_flag <= 1'b0;
                    end
                end
                ARMED: begin
                    // A one-byte file skips STREAM and goes straight to draining.
                    if (last_push) begin
                        state    <= DRAIN;
                        eof_seen <= 1'b1;
                    end else if (push) begin
                        state  <= STREAM;
                        wd_cnt <= TIMEOUT - 24'd1;
                    end
                end
                STREAM: begin
                    if (last_push) begin
                        state    <= DRAIN;
                        eof_seen <= 1'b1;
                    end else if (pop) begin
                        wd_cnt <= TIMEOUT - 24'd1;
                    end else if (timeout_hit) begin
                        state        <= IDLE;
                        override     <= 1'b0;
                        timeout_flag <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt - 24'd1;
                    end
                end
                DRAIN: begin
                    if (pop && head[8]) begin
                        state    <= IDLE;
                        override <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    override <= 1'b0;
                end
            endcase
        end
    end

endmodule
